router_arbiter: RTL and testbench
=================================

# router_arbiter

Round-robin packet scheduler that shares the single 4-destination router between NUM_REQ requesters. Each requester offers beats with a 2-bit destination address over a valid/ready handshake. The block grants the router to one requester per packet and locks it until that requester's `last` beat. Accepted beats are registered and presented to the router as `din`/`din_en`/`addr`.

## Interface
Parameters:
- DATA_WIDTH, 32, beat width; matches the router data width.
- NUM_REQ, 4, number of requesters; legal range 2..8.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_data  in  NUM_REQ*DATA_WIDTH  packed beats; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_addr  in  NUM_REQ*2  packed destination; requester i occupies bits [i*2 +: 2].
- req_last  in  NUM_REQ  final beat of the packet.
- req_ready  out  NUM_REQ  per-requester accept; combinational.
- dst_ready  in  4  destination d can absorb a beat in the next cycle.
- din  out  DATA_WIDTH  router data (registered).
- din_en  out  1  router enable (registered).
- addr  out  2  router destination select (registered).
- grant_id  out  $clog2(NUM_REQ)  current or last owner.
- busy  out  1  high while a packet is locked (state LOCKED).

## Operation
- Accept: a beat from requester i is accepted when `req_valid[i] && req_ready[i]`. At most one `req_ready` bit is high in any cycle.
- FSM has two states, IDLE and LOCKED. Reset enters IDLE.
- IDLE:
  - Eligible requesters: `req_valid[i] && dst_ready[req_addr_i]`.
  - Winner: the first eligible requester found by scanning from `ptr` upward, modulo NUM_REQ. `req_ready[winner]=1`.
  - No eligible requester: no accept; `ptr` and the state are unchanged.
  - Winner's beat has `last=1`: single-beat packet. Stay in IDLE; `ptr <= winner+1` (mod NUM_REQ).
  - Winner's beat has `last=0`: go to LOCKED; `owner <= winner`; `lock_addr <= req_addr_winner`.
- LOCKED:
  - `req_ready[owner] = dst_ready[lock_addr]`; all other `req_ready` bits are 0.
  - `req_addr` is ignored for the owner's beats; `lock_addr` is used instead.
  - If the owner drops `req_valid`, the packet stalls indefinitely; there is no timeout.
  - On an accepted `last` beat: go to IDLE; `ptr <= owner+1` (mod NUM_REQ).
- Fairness: once a requester is valid with its destination ready, it is granted within NUM_REQ-1 packets.
- `grant_id` is updated on every accept and holds its value otherwise.

## Timing
- Latency: a beat accepted in cycle N gives `din_en=1`, `din=beat` and `addr=dest` in cycle N+1, for exactly one cycle.
- No accept in cycle N gives `din_en=0` in N+1. `din` and `addr` hold their last accepted values.
- Throughput: one beat per cycle. Back-to-back packets are possible; IDLE arbitration happens in the same cycle as the accept, so no bubble is inserted.
- `busy` is registered. It rises in the cycle after a non-last first beat and falls in the cycle after the last beat.
- Reset values: `din=0`, `din_en=0`, `addr=0`, `grant_id=0`, `busy=0`, `ptr=0`, `owner=0`, `lock_addr=0`, state=IDLE.
- While `reset=1`, all `req_ready` bits are 0.
- Reset in the middle of a packet abandons the packet. `din_en` is 0 in the cycle after reset is sampled.
- `ptr` wraps from NUM_REQ-1 to 0.
- `dst_ready` is sampled in the accept cycle only; there is no skid buffer.

## Structure
- Package `router_pkg` holds:
  - `ADDR_W=2` and `NUM_DST=4`.
  - State enum `arb_state_e` with values `IDLE` and `LOCKED`.
- Sub-module `rr_arbiter #(N)` contains the combinational masked-priority search:
  - Inputs: eligible vector and `ptr`.
  - Outputs: one-hot grant, encoded winner index, and `any_grant`.
  - It is instantiated once. The FSM, lock registers and output register stay in `router_arbiter`.

## Test plan
- Reset behaviour: reset for 2 cycles while requester 0 holds valid, last=1, data 0xA5A5A5A5, addr 1.
  - During reset: `req_ready=0` and `din_en=0`.
  - First cycle after release: accept.
  - Next cycle: `din=0xA5A5A5A5`, `addr=1`, `din_en=1`.
- Round-robin, all single-beat: all 4 requesters continuously valid with last=1, all `dst_ready=1`. Grant order is 0,1,2,3,0 on consecutive cycles, and `din_en` stays high continuously.
- Packet lock: requester 2 sends a 3-beat packet to addr 3 while requester 0 is valid throughout.
  - The three beats of requester 2 appear contiguously with `addr=3`, even if `req_addr` changes mid-packet.
  - Requester 0 is granted next.
- Backpressure: owner locked to addr 1 with `dst_ready[1]` toggling 1,0,0,1. Beats are accepted only in the ready cycles, and `din_en` pattern is 1,0,0,1 with a one-cycle lag.
- Ineligible skip: `ptr=1`; requester 1 targets addr 2 with `dst_ready[2]=0`; requester 3 targets addr 0 with `dst_ready[0]=1`. Requester 3 is granted, and `ptr` becomes 0.
- Reset mid-packet: reset asserted after beat 2 of a 4-beat packet. State returns to IDLE, `busy=0`, `ptr=0`, and a new packet from any requester is arbitrated normally.

Source files
------------

// File: rtl/router_pkg.sv
// Shared widths and FSM state encoding for the router arbiter slice.
package router_pkg;
    localparam int ADDR_W  = 2;
    localparam int NUM_DST = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first eligible requester at or above ptr, wrapping.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  i_elig,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [PW-1:0] o_idx,
    output logic          o_any
);

    logic [PW-1:0] w_idx;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = PW'((int'(i_ptr) + k) % N);
            if (!o_any && i_elig[w_idx]) begin
                o_any          = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_idx          = w_idx;
            end
        end
    end

endmodule

// File: rtl/router_arbiter.sv
// Packet-locked round-robin scheduler feeding the shared 4-destination router.
//
// state  | meaning
// IDLE   | arbitrate every cycle; single-beat packets stay here
// LOCKED | owner holds the router until its last beat, destination frozen
module router_arbiter
    import router_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_DST-1:0]            dst_ready,
    output logic [DATA_WIDTH-1:0]         din,
    output logic                          din_en,
    output logic [ADDR_W-1:0]             addr,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    localparam int PW = $clog2(NUM_REQ);

    arb_state_e            r_state;
    logic [PW-1:0]         r_ptr;
    logic [PW-1:0]         r_owner;
    logic [ADDR_W-1:0]     r_lock_addr;
    logic [DATA_WIDTH-1:0] r_din;
    logic                  r_din_en;
    logic [ADDR_W-1:0]     r_addr;
    logic [PW-1:0]         r_grant_id;
    logic                  r_busy;

    logic [NUM_REQ-1:0]    w_elig;
    logic [NUM_REQ-1:0]    w_grant;
    logic [PW-1:0]         w_win;
    logic                  w_any;
    logic [PW-1:0]         w_sel_idx;
    logic [PW-1:0]         w_sel_next;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic [ADDR_W-1:0]     w_req_addr;
    logic [ADDR_W-1:0]     w_sel_addr;
    logic                  w_sel_last;
    logic                  w_accept;

    // A requester only competes when the router output it targets can take the beat.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_elig
        assign w_elig[g] = req_valid[g] && dst_ready[req_addr[g*ADDR_W +: ADDR_W]];
    end

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .i_elig  (w_elig),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_win),
        .o_any   (w_any)
    );

    always_comb begin
        w_sel_idx  = (r_state == IDLE) ? w_win : r_owner;
        w_sel_data = '0;
        w_req_addr = '0;
        w_sel_last = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (PW'(i) == w_sel_idx) begin
                w_sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                w_req_addr = req_addr[i*ADDR_W +: ADDR_W];
                w_sel_last = req_last[i];
            end
        end
        w_sel_addr = (r_state == IDLE) ? w_req_addr : r_lock_addr;
        w_sel_next = (w_sel_idx == PW'(NUM_REQ - 1)) ? '0 : w_sel_idx + 1'b1;
    end

    always_comb begin
        req_ready = '0;
        if (!reset) begin
            case (r_state)
                IDLE:    req_ready = w_any ? w_grant : '0;
                LOCKED:  req_ready[r_owner] = dst_ready[r_lock_addr];
                default: req_ready = '0;
            endcase
        end
    end

    assign w_accept = |(req_valid & req_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_owner     <= '0;
            r_lock_addr <= '0;
            r_din       <= '0;
            r_din_en    <= 1'b0;
            r_addr      <= '0;
            r_grant_id  <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_din_en <= w_accept;
            if (w_accept) begin
                r_din      <= w_sel_data;
                r_addr     <= w_sel_addr;
                r_grant_id <= w_sel_idx;
            end
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_sel_last) begin
                            r_ptr <= w_sel_next;
                        end else begin
                            r_state     <= LOCKED;
                            r_owner     <= w_sel_idx;
                            r_lock_addr <= w_req_addr;
                            r_busy      <= 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (w_accept && w_sel_last) begin
                        r_state <= IDLE;
                        r_ptr   <= w_sel_next;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign din      = r_din;
    assign din_en   = r_din_en;
    assign addr     = r_addr;
    assign grant_id = r_grant_id;
    assign busy     = r_busy;

endmodule

// File: tb/tb_router_arbiter.sv
// Directed bench for router_arbiter with an expected-beat queue.
module tb_router_arbiter;

    localparam int DW = 32;
    localparam int NR = 4;

    logic           clk;
    logic           reset;
    logic [NR-1:0]  req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR*2-1:0]  req_addr;
    logic [NR-1:0]  req_last;
    logic [NR-1:0]  req_ready;
    logic [3:0]     dst_ready;
    logic [DW-1:0]  din;
    logic           din_en;
    logic [1:0]     addr;
    logic [1:0]     grant_id;
    logic           busy;

    router_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_addr  (req_addr),
        .req_last  (req_last),
        .req_ready (req_ready),
        .dst_ready (dst_ready),
        .din       (din),
        .din_en    (din_en),
        .addr      (addr),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          en;
        logic [DW-1:0] din;
        logic [1:0]    addr;
        logic [1:0]    gid;
        logic          busy;
    } exp_t;

    exp_t          exp_q[$];
    int            n_assert = 0;
    int            n_fail   = 0;
    logic [DW-1:0] m_din  = '0;
    logic [1:0]    m_addr = '0;
    logic [1:0]    m_gid  = '0;

    task automatic chk1(input logic obs, input logic exp, input string tag);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkv(input logic [DW-1:0] obs, input logic [DW-1:0] exp, input string tag);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [DW-1:0] d,
                           input logic [1:0] a, input logic l);
        req_valid[i]       = v;
        req_data[i*DW +: DW] = d;
        req_addr[i*2 +: 2] = a;
        req_last[i]        = l;
    endtask

    // Inputs are already driven; checks ready now, then the registered result one edge later.
    task automatic tick(input logic [3:0] exp_rdy, input logic [1:0] exp_addr,
                        input logic exp_busy, input string tag);
        exp_t e;
        int   sel;
        #1;
        chkv(DW'(req_ready), DW'(exp_rdy), {tag, " req_ready"});
        sel = 0;
        for (int i = 0; i < NR; i++) if (exp_rdy[i]) sel = i;
        e.en = |(exp_rdy & req_valid);
        if (e.en) begin
            m_din  = req_data[sel*DW +: DW];
            m_addr = exp_addr;
            m_gid  = 2'(sel);
        end
        e.din  = m_din;
        e.addr = m_addr;
        e.gid  = m_gid;
        e.busy = exp_busy;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk1(din_en, e.en, {tag, " din_en"});
        chkv(din, e.din, {tag, " din"});
        chkv(DW'(addr), DW'(e.addr), {tag, " addr"});
        chkv(DW'(grant_id), DW'(e.gid), {tag, " grant_id"});
        chk1(busy, e.busy, {tag, " busy"});
    endtask

    task automatic do_reset(input int n, input string tag);
        reset = 1'b1;
        for (int c = 0; c < n; c++) begin
            #1;
            chkv(DW'(req_ready), '0, {tag, " rst req_ready"});
            @(posedge clk);
            #1;
            chk1(din_en, 1'b0, {tag, " rst din_en"});
            chkv(din, '0, {tag, " rst din"});
            chkv(DW'(addr), '0, {tag, " rst addr"});
            chkv(DW'(grant_id), '0, {tag, " rst grant_id"});
            chk1(busy, 1'b0, {tag, " rst busy"});
        end
        m_din  = '0;
        m_addr = '0;
        m_gid  = '0;
        reset  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_addr  = '0;
        req_last  = '0;
        dst_ready = 4'hF;

        // Reset with requester 0 already offering a beat
        set_req(0, 1'b1, 32'hA5A5A5A5, 2'd1, 1'b1);
        do_reset(2, "reset");
        tick(4'b0001, 2'd1, 1'b0, "first_accept");
        req_valid = '0;

        // Round robin, all single-beat, starting from ptr=0
        do_reset(1, "rr_reset");
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 32'h1000_0000 + i, 2'(i), 1'b1);
        tick(4'b0001, 2'd0, 1'b0, "rr0");
        tick(4'b0010, 2'd1, 1'b0, "rr1");
        tick(4'b0100, 2'd2, 1'b0, "rr2");
        tick(4'b1000, 2'd3, 1'b0, "rr3");
        tick(4'b0001, 2'd0, 1'b0, "rr4");
        req_valid = '0;

        // Packet lock: ptr=1, requester 2 sends 3 beats to addr 3, requester 0 waits
        set_req(0, 1'b1, 32'h0000_00AA, 2'd0, 1'b1);
        set_req(2, 1'b1, 32'h2222_0001, 2'd3, 1'b0);
        tick(4'b0100, 2'd3, 1'b1, "lock_b1");
        set_req(2, 1'b1, 32'h2222_0002, 2'd0, 1'b0);
        tick(4'b0100, 2'd3, 1'b1, "lock_b2");
        set_req(2, 1'b1, 32'h2222_0003, 2'd1, 1'b1);
        tick(4'b0100, 2'd3, 1'b0, "lock_b3");
        req_valid[2] = 1'b0;
        tick(4'b0001, 2'd0, 1'b0, "lock_next");

        // Backpressure: requester 1 locked to addr 1, dst_ready[1] = 1,0,0,1
        set_req(1, 1'b1, 32'h1111_0001, 2'd1, 1'b0);
        tick(4'b0010, 2'd1, 1'b1, "bp_head");
        set_req(1, 1'b1, 32'h1111_0002, 2'd1, 1'b0);
        tick(4'b0010, 2'd1, 1'b1, "bp_r1");
        set_req(1, 1'b1, 32'h1111_0003, 2'd1, 1'b1);
        dst_ready = 4'b1101;
        tick(4'b0000, 2'd1, 1'b1, "bp_r0a");
        tick(4'b0000, 2'd1, 1'b1, "bp_r0b");
        dst_ready = 4'b1111;
        tick(4'b0010, 2'd1, 1'b0, "bp_r1_last");
        req_valid[1] = 1'b0;
        tick(4'b0001, 2'd0, 1'b0, "bp_after");
        req_valid = '0;

        // Ineligible skip: ptr=1, requester 1 blocked on addr 2, requester 3 wins
        set_req(1, 1'b1, 32'h5151_5151, 2'd2, 1'b1);
        set_req(3, 1'b1, 32'h5353_5353, 2'd0, 1'b1);
        dst_ready = 4'b1011;
        tick(4'b1000, 2'd0, 1'b0, "skip");
        req_valid[1] = 1'b0;
        set_req(0, 1'b1, 32'h5050_5050, 2'd0, 1'b1);
        dst_ready = 4'hF;
        tick(4'b0001, 2'd0, 1'b0, "skip_ptr0");
        req_valid = '0;
        tick(4'b0000, 2'd0, 1'b0, "idle_none");

        // Reset after beat 2 of a 4-beat packet from requester 2 (ptr=1)
        set_req(2, 1'b1, 32'h6262_0001, 2'd2, 1'b0);
        tick(4'b0100, 2'd2, 1'b1, "mid_b1");
        set_req(2, 1'b1, 32'h6262_0002, 2'd2, 1'b0);
        tick(4'b0100, 2'd2, 1'b1, "mid_b2");
        do_reset(1, "mid_reset");
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 32'h7000_0000 + i, 2'(3 - i), 1'b1);
        tick(4'b0001, 2'd3, 1'b0, "post_rst0");
        tick(4'b0010, 2'd2, 1'b0, "post_rst1");
        req_valid = '0;
        tick(4'b0000, 2'd0, 1'b0, "post_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
